io_port_ctrl: RTL

- Streaming I/O scheduler between external sample producers/consumers and the soft float processor's port-addressed I/O.
- Buffers one word per input port behind a valid/ready handshake and presents it when the processor's one-hot read strobe selects that port.
- Captures processor writes on the one-hot write strobe into per-port output slots drained by valid/ready.
- Flags processor reads of empty ports (underflow) and overwrites of undrained outputs (overrun).

---
 rtl/io_port_ctrl_pkg.sv | 11 +
 rtl/io_port_ctrl_slot.sv | 53 +++++
 rtl/io_port_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/io_port_ctrl_pkg.sv
// io_port_ctrl_pkg: shared defaults for the processor I/O scheduler.
//   NUBITS_DEF : float word width (1 sign + exponent + mantissa bits)
//   NUIOIN_DEF : number of processor input ports
//   NUIOOU_DEF : number of processor output ports
package io_port_ctrl_pkg;

  localparam int NUBITS_DEF = 28;
  localparam int NUIOIN_DEF = 4;
  localparam int NUIOOU_DEF = 4;

endpackage : io_port_ctrl_pkg

// File: rtl/io_port_ctrl_slot.sv
// io_slot: one-entry word buffer with a full flag.
//   clk, rst : clock and synchronous active-high reset
//   load     : capture din (wins over consume when both are high)
//   consume  : the held word is taken this cycle
//   din      : incoming word
//   full     : slot holds an unconsumed word
//   dout     : last stored word (held after consume, cleared only by reset)
module io_slot
  import io_port_ctrl_pkg::*;
#(
  parameter int W = NUBITS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         consume,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // next-state for the full flag and held word
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = din;
    end else if (consume) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // slot state register
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule : io_slot

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: streaming I/O scheduler between sample producers/consumers and
// the soft float processor's port-addressed I/O.
//   clk, rst              : clock, synchronous active-high reset
//   src_data/valid/ready  : producer side, one 1-deep slot per input port
//   req_in                : one-hot processor read strobe (lowest bit wins)
//   proc_in               : combinational word for the selected input port
//   out_en, proc_out      : processor write strobe (multi-hot allowed) and word
//   snk_data/valid/ready  : consumer side, one 1-deep slot per output port
//   clr_err               : clears the sticky flags (new errors still win)
//   underflow             : sticky, input port read while empty
//   overrun               : sticky, output slot overwritten before drain
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NUIOIN = NUIOIN_DEF,
  parameter int NUIOOU = NUIOOU_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUIOIN*NUBITS-1:0] src_data,
  input  logic [NUIOIN-1:0]        src_valid,
  output logic [NUIOIN-1:0]        src_ready,
  input  logic [NUIOIN-1:0]        req_in,
  output logic [NUBITS-1:0]        proc_in,
  input  logic [NUIOOU-1:0]        out_en,
  input  logic [NUBITS-1:0]        proc_out,
  output logic [NUIOOU*NUBITS-1:0] snk_data,
  output logic [NUIOOU-1:0]        snk_valid,
  input  logic [NUIOOU-1:0]        snk_ready,
  input  logic                     clr_err,
  output logic [NUIOIN-1:0]        underflow,
  output logic [NUIOOU-1:0]        overrun
);

  logic [NUIOIN-1:0]        sel;
  logic [NUIOIN-1:0]        in_full;
  logic [NUIOIN*NUBITS-1:0] in_dout;
  logic [NUIOOU-1:0]        out_full;
  logic [NUIOOU-1:0]        out_drain;
  logic [NUIOIN-1:0]        underflow_q, underflow_d;
  logic [NUIOOU-1:0]        overrun_q, overrun_d;

  // Isolate the lowest set bit so a multi-hot strobe serves exactly one port.
  assign sel = req_in & (~req_in + NUIOIN'(1));

  // A port being read this cycle frees its slot for a same-cycle load.
  assign src_ready = ~in_full | sel;
  assign out_drain = out_full & snk_ready;

  for (genvar i = 0; i < NUIOIN; i++) begin : g_in
    io_slot #(.W(NUBITS)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (src_valid[i] & src_ready[i]),
      .consume (sel[i]),
      .din     (src_data[i*NUBITS +: NUBITS]),
      .full    (in_full[i]),
      .dout    (in_dout[i*NUBITS +: NUBITS])
    );
  end

  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    io_slot #(.W(NUBITS)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (out_en[j]),
      .consume (out_drain[j]),
      .din     (proc_out),
      .full    (out_full[j]),
      .dout    (snk_data[j*NUBITS +: NUBITS])
    );
  end

  assign snk_valid = out_full;

  // proc_in mux: sel is at most one-hot, so OR-ing the gated words is exact.
  always_comb begin
    proc_in = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (sel[i]) begin
        proc_in = proc_in | in_dout[i*NUBITS +: NUBITS];
      end else begin
        proc_in = proc_in;
      end
    end
  end

  // sticky error flags; a fresh error in the clearing cycle survives the clear
  always_comb begin
    if (clr_err) begin
      underflow_d = sel & ~in_full;
      overrun_d   = out_en & out_full & ~snk_ready;
    end else begin
      underflow_d = underflow_q | (sel & ~in_full);
      overrun_d   = overrun_q | (out_en & out_full & ~snk_ready);
    end
  end

  // error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_q <= '0;
      overrun_q   <= '0;
    end else begin
      underflow_q <= underflow_d;
      overrun_q   <= overrun_d;
    end
  end

  assign underflow = underflow_q;
  assign overrun   = overrun_q;

endmodule : io_port_ctrl
